// File: rtl/btb_table_if.sv
// Bus bundle between the fetch/execute stages and the branch target buffer.
// Groups the operation request (enable, op, update PC/target) and the lookup
// side (fetch PC and the combinational hit/prediction/target results) plus the
// occupancy status outputs.
//   master : drives enable, op, pc, upd_pc, upd_target; observes results
//   slave  : the BTB itself; the mirror image of master
interface btb_table_if #(
  parameter int ENTRIES = 8,
  parameter int PC_W    = 16
);
  localparam int CNT_W = $clog2(ENTRIES) + 1;

  logic             enable;
  logic [2:0]       op;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  upd_pc;
  logic [PC_W-1:0]  upd_target;
  logic             hit;
  logic             prediction;
  logic [PC_W-1:0]  out_target;
  logic             full;
  logic [CNT_W-1:0] valid_count;

  modport master (
    output enable, op, pc, upd_pc, upd_target,
    input  hit, prediction, out_target, full, valid_count
  );

  modport slave (
    input  enable, op, pc, upd_pc, upd_target,
    output hit, prediction, out_target, full, valid_count
  );
endinterface

// File: rtl/btb_table.sv
// Fully-associative branch target buffer.
// Each entry holds a PC tag, a branch target and a 2-bit saturating predictor.
// Lookup on bus.pc is purely combinational (zero latency, independent of op and
// enable). Verify and insert operations use bus.upd_pc / bus.upd_target and take
// effect on the rising clock edge. Insert dedups on tag, then fills the lowest
// invalid slot, then falls back to a round-robin victim pointer.
// Ports:
//   clk    : clock, all state changes on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : btb_table_if slave modport (op request, lookup, status)
module btb_table #(
  parameter int ENTRIES = 8,
  parameter int PC_W    = 16,
  parameter int TAG_LSB = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  btb_table_if.slave   bus
);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CNT_W = $clog2(ENTRIES) + 1;
  localparam int TAG_W = PC_W - TAG_LSB;

  typedef enum logic [2:0] {
    OP_IDLE     = 3'b000,
    OP_CLEAR    = 3'b001,
    OP_VERIFY_F = 3'b010,
    OP_VERIFY_T = 3'b011,
    OP_LOOKUP   = 3'b100,
    OP_INSERT_F = 3'b110,
    OP_INSERT_T = 3'b111
  } op_e;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];
  logic [PC_W-1:0]    target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic [TAG_W-1:0]   pc_tag;
  logic [TAG_W-1:0]   upd_tag;
  logic               lk_hit;
  logic               lk_pred;
  logic [PC_W-1:0]    lk_tgt;
  logic               upd_hit;
  logic [IDX_W-1:0]   upd_idx;
  logic               free_hit;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   slot;
  logic [CNT_W-1:0]   cnt;

  assign pc_tag  = bus.pc[PC_W-1:TAG_LSB];
  assign upd_tag = bus.upd_pc[PC_W-1:TAG_LSB];

  // Combinational lookup; tags are unique so OR-merging the matches is exact.
  always_comb begin
    lk_hit  = 1'b0;
    lk_pred = 1'b0;
    lk_tgt  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      lk_hit  = lk_hit  | (valid_q[i] && (tag_q[i] == pc_tag));
      lk_pred = lk_pred | ((valid_q[i] && (tag_q[i] == pc_tag)) & ctr_q[i][1]);
      lk_tgt  = lk_tgt  | ({PC_W{valid_q[i] && (tag_q[i] == pc_tag)}} & target_q[i]);
    end
  end

  // Update-side search: matching entry and lowest-index free slot.
  always_comb begin
    upd_hit  = 1'b0;
    upd_idx  = '0;
    free_hit = 1'b0;
    free_idx = '0;
    // Walk downward so the last assignment is the lowest free index.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      upd_hit  = upd_hit | (valid_q[i] && (tag_q[i] == upd_tag));
      upd_idx  = (valid_q[i] && (tag_q[i] == upd_tag)) ? IDX_W'(i) : upd_idx;
      free_hit = free_hit | !valid_q[i];
      free_idx = !valid_q[i] ? IDX_W'(i) : free_idx;
    end
  end

  // Occupancy count derived from the valid bits.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      cnt = cnt + CNT_W'(valid_q[i]);
    end
  end

  // Next-state computation for clear / verify / insert.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    ptr_d    = ptr_q;
    slot     = '0;
    if (bus.enable) begin
      case (op_e'(bus.op))
        OP_CLEAR: begin
          valid_d = '0;
          ptr_d   = '0;
          for (int i = 0; i < ENTRIES; i++) begin
            tag_d[i]    = '0;
            target_d[i] = '0;
            ctr_d[i]    = 2'b01;
          end
        end
        OP_VERIFY_T: begin
          if (upd_hit && (ctr_q[upd_idx] != 2'b11)) begin
            ctr_d[upd_idx] = ctr_q[upd_idx] + 2'b01;
          end else begin
            ctr_d[upd_idx] = ctr_q[upd_idx];
          end
        end
        OP_VERIFY_F: begin
          if (upd_hit && (ctr_q[upd_idx] != 2'b00)) begin
            ctr_d[upd_idx] = ctr_q[upd_idx] - 2'b01;
          end else begin
            ctr_d[upd_idx] = ctr_q[upd_idx];
          end
        end
        OP_INSERT_T, OP_INSERT_F: begin
          if (upd_hit) begin
            slot = upd_idx;
          end else if (free_hit) begin
            slot = free_idx;
          end else begin
            // Round-robin victim; ENTRIES is a power of 2 so the add wraps.
            slot  = ptr_q;
            ptr_d = ptr_q + IDX_W'(1);
          end
          valid_d[slot]  = 1'b1;
          tag_d[slot]    = upd_tag;
          target_d[slot] = bus.upd_target;
          ctr_d[slot]    = (op_e'(bus.op) == OP_INSERT_T) ? 2'b10 : 2'b01;
        end
        default: begin
          valid_d = valid_q;
        end
      endcase
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ptr_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
      ptr_q    <= ptr_d;
    end
  end

  assign bus.hit         = lk_hit;
  assign bus.prediction  = lk_pred;
  assign bus.out_target  = lk_tgt;
  assign bus.full        = &valid_q;
  assign bus.valid_count = cnt;
endmodule

// File: tb/tb_btb_table.sv
// Directed self-checking bench for btb_table (ENTRIES=8, PC_W=16, TAG_LSB=1).
module tb_btb_table;
  localparam logic [2:0] IDLE = 3'b000, CLR = 3'b001, VF = 3'b010, VT = 3'b011;
  localparam logic [2:0] IF_ = 3'b110, IT = 3'b111;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  btb_table_if #(.ENTRIES(8), .PC_W(16)) bus ();

  btb_table #(.ENTRIES(8), .PC_W(16), .TAG_LSB(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [15:0] up, input logic [15:0] tg,
                       input logic en);
    @(negedge clk);
    bus.enable     = en;
    bus.op         = o;
    bus.upd_pc     = up;
    bus.upd_target = tg;
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
    bus.op     = IDLE;
  endtask

  task automatic look(input logic [15:0] p);
    bus.pc = p;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.enable = 1'b0; bus.op = IDLE; bus.pc = 16'h0000;
    bus.upd_pc = 16'h0000; bus.upd_target = 16'h0000;
    rst_n = 1'b0;
    #12;
    // 1 reset
    look(16'h0040);
    chk("rst_hit", 32'(bus.hit), 32'd0);
    chk("rst_tgt", 32'(bus.out_target), 32'd0);
    chk("rst_cnt", 32'(bus.valid_count), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    rst_n = 1'b1;

    // 2 insert target
    do_op(IT, 16'h0040, 16'h0100, 1'b1);
    look(16'h0040);
    chk("ins_hit", 32'(bus.hit), 32'd1);
    chk("ins_pred", 32'(bus.prediction), 32'd1);
    chk("ins_tgt", 32'(bus.out_target), 32'h0100);
    chk("ins_cnt", 32'(bus.valid_count), 32'd1);
    look(16'h0041);
    chk("lsb_ignored_hit", 32'(bus.hit), 32'd1);
    look(16'h0042);
    chk("miss_hit", 32'(bus.hit), 32'd0);
    chk("miss_tgt", 32'(bus.out_target), 32'd0);
    chk("miss_pred", 32'(bus.prediction), 32'd0);

    // 3 counter path: 10 -> 01
    look(16'h0040);
    do_op(VF, 16'h0040, 16'h0000, 1'b1);
    chk("vf1_pred", 32'(bus.prediction), 32'd0);
    // 01 -> 00 -> 00 -> 00
    for (int i = 0; i < 3; i++) do_op(VF, 16'h0040, 16'h0000, 1'b1);
    chk("vf3_pred", 32'(bus.prediction), 32'd0);
    // 00 -> 01 (still not taken proves floor held at 00)
    do_op(VT, 16'h0040, 16'h0000, 1'b1);
    chk("floor_pred", 32'(bus.prediction), 32'd0);
    // 01 -> 10
    do_op(VT, 16'h0040, 16'h0000, 1'b1);
    chk("vt2_pred", 32'(bus.prediction), 32'd1);
    // 10 -> 11 -> 11 -> 11
    for (int i = 0; i < 3; i++) do_op(VT, 16'h0040, 16'h0000, 1'b1);
    chk("sat_pred", 32'(bus.prediction), 32'd1);
    // 11 -> 10 (taken) -> 01 (not taken)
    do_op(VF, 16'h0040, 16'h0000, 1'b1);
    chk("ceil1_pred", 32'(bus.prediction), 32'd1);
    do_op(VF, 16'h0040, 16'h0000, 1'b1);
    chk("ceil2_pred", 32'(bus.prediction), 32'd0);
    // verify on a non-resident PC changes nothing
    do_op(VT, 16'h0080, 16'h0000, 1'b1);
    chk("vmiss_pred", 32'(bus.prediction), 32'd0);
    chk("vmiss_cnt", 32'(bus.valid_count), 32'd1);
    // same-cycle lookup sees pre-edge value (01 -> 10 on this edge)
    @(negedge clk);
    bus.enable = 1'b1; bus.op = VT; bus.upd_pc = 16'h0040;
    #1;
    chk("same_cyc_pre", 32'(bus.prediction), 32'd0);
    @(posedge clk);
    #1;
    bus.enable = 1'b0; bus.op = IDLE;
    chk("same_cyc_post", 32'(bus.prediction), 32'd1);

    // 4 dedup insert
    do_op(IF_, 16'h0040, 16'h0200, 1'b1);
    chk("dedup_cnt", 32'(bus.valid_count), 32'd1);
    chk("dedup_tgt", 32'(bus.out_target), 32'h0200);
    chk("dedup_pred", 32'(bus.prediction), 32'd0);
    // insert with enable=0 is ignored
    do_op(IT, 16'h0500, 16'h0600, 1'b0);
    chk("en0_cnt", 32'(bus.valid_count), 32'd1);

    // 5 fill entries 1..7 with 0x1002,0x1004,...,0x100E
    for (int i = 1; i < 7; i++) do_op(IT, 16'h1000 + 16'(2 * i), 16'h4000 + 16'(i), 1'b1);
    chk("fill7_cnt", 32'(bus.valid_count), 32'd7);
    chk("fill7_full", 32'(bus.full), 32'd0);
    do_op(IT, 16'h100E, 16'h4007, 1'b1);
    chk("fill8_cnt", 32'(bus.valid_count), 32'd8);
    chk("fill8_full", 32'(bus.full), 32'd1);
    // 9th insert evicts entry0 (0x0040)
    do_op(IT, 16'h2000, 16'h3000, 1'b1);
    look(16'h0040);
    chk("evict0_miss", 32'(bus.hit), 32'd0);
    look(16'h2000);
    chk("ins9_tgt", 32'(bus.out_target), 32'h3000);
    chk("ins9_cnt", 32'(bus.valid_count), 32'd8);
    // 10th insert evicts entry1 (0x1002)
    do_op(IT, 16'h2002, 16'h3002, 1'b1);
    look(16'h1002);
    chk("evict1_miss", 32'(bus.hit), 32'd0);
    look(16'h1004);
    chk("keep2_tgt", 32'(bus.out_target), 32'h4002);
    look(16'h2002);
    chk("ins10_tgt", 32'(bus.out_target), 32'h3002);

    // 6 CLEAR with enable=0 does nothing
    do_op(CLR, 16'h0000, 16'h0000, 1'b0);
    chk("clr_en0_cnt", 32'(bus.valid_count), 32'd8);
    do_op(CLR, 16'h0000, 16'h0000, 1'b1);
    chk("clr_cnt", 32'(bus.valid_count), 32'd0);
    chk("clr_full", 32'(bus.full), 32'd0);
    chk("clr_hit", 32'(bus.hit), 32'd0);
    // after clear, insert lands in slot 0 and fill order restarts
    do_op(IF_, 16'h0700, 16'h0900, 1'b1);
    look(16'h0700);
    chk("post_clr_tgt", 32'(bus.out_target), 32'h0900);
    chk("post_clr_pred", 32'(bus.prediction), 32'd0);
    // async reset pulse between edges
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_cnt", 32'(bus.valid_count), 32'd0);
    chk("async_hit", 32'(bus.hit), 32'd0);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
